// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 32;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } hazard_state_t;

   // Per-cycle pipeline register controls
   typedef struct packed {
      logic pc_ld;
      logic ifid_ld;
      logic idex_ld;
      logic exmem_ld;
      logic memwb_ld;
      logic ifid_flush;
      logic idex_flush;
      logic pc_redirect_en;
   } hazard_ctl_t;

endpackage

// File: rtl/hazard_perf_counters.sv
// Free-running stall and flush event counters, wrapping modulo 2^32.
module hazard_perf_counters
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             istall_inc_i,
   input  logic             dstall_inc_i,
   input  logic             flush_inc_i,
   output logic [CNT_W-1:0] istall_cnt_o,
   output logic [CNT_W-1:0] dstall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   logic [CNT_W-1:0] istall_q, dstall_q, flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         istall_q <= '0;
         dstall_q <= '0;
         flush_q  <= '0;
      end else begin
         if (istall_inc_i) istall_q <= istall_q + CNT_W'(1);
         if (dstall_inc_i) dstall_q <= dstall_q + CNT_W'(1);
         if (flush_inc_i)  flush_q  <= flush_q + CNT_W'(1);
      end
   end

   assign istall_cnt_o = istall_q;
   assign dstall_cnt_o = dstall_q;
   assign flush_cnt_o  = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: turns cache misses and taken branches into pipeline
// register load/flush enables, with a SQUASH state for branches racing a fetch.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_req,
   input  logic             icache_resp,
   input  logic             mem_req,
   input  logic             dcache_resp,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  br_target,
   output logic             pc_ld,
   output logic             ifid_ld,
   output logic             idex_ld,
   output logic             exmem_ld,
   output logic             memwb_ld,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pc_redirect_en,
   output logic [XLEN-1:0]  pc_redirect,
   output logic [CNT_W-1:0] istall_cnt,
   output logic [CNT_W-1:0] dstall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hazard_state_t   state_q, state_d;
   logic [XLEN-1:0] redirect_q, redirect_d;
   hazard_ctl_t     ctl;
   logic            dstall, istall, in_squash, flush_inc;

   assign in_squash = (state_q == SQUASH);
   assign dstall    = mem_req & ~dcache_resp;
   assign istall    = (if_req & ~icache_resp) | (in_squash & ~icache_resp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         redirect_q <= '0;
      end else begin
         state_q    <= state_d;
         redirect_q <= redirect_d;
      end
   end

   // Enables are combinational; priority is dstall > SQUASH > branch > istall
   always_comb begin
      ctl        = '0;
      state_d    = state_q;
      redirect_d = redirect_q;
      flush_inc  = 1'b0;
      if (!rst_n || dstall) begin
         ctl = '0;
      end else if (in_squash) begin
         ctl.ifid_ld    = 1'b1;
         ctl.idex_ld    = 1'b1;
         ctl.exmem_ld   = 1'b1;
         ctl.memwb_ld   = 1'b1;
         ctl.ifid_flush = 1'b1;
         if (icache_resp) begin
            ctl.pc_ld          = 1'b1;
            ctl.pc_redirect_en = 1'b1;
            state_d            = RUN;
         end
      end else if (br_taken) begin
         ctl.ifid_ld    = 1'b1;
         ctl.idex_ld    = 1'b1;
         ctl.exmem_ld   = 1'b1;
         ctl.memwb_ld   = 1'b1;
         ctl.ifid_flush = 1'b1;
         ctl.idex_flush = 1'b1;
         flush_inc      = 1'b1;
         if (istall) begin
            redirect_d = br_target;
            state_d    = SQUASH;
         end else begin
            ctl.pc_ld = 1'b1;
         end
      end else if (istall) begin
         ctl.idex_ld    = 1'b1;
         ctl.idex_flush = 1'b1;
         ctl.exmem_ld   = 1'b1;
         ctl.memwb_ld   = 1'b1;
      end else begin
         ctl.pc_ld    = 1'b1;
         ctl.ifid_ld  = 1'b1;
         ctl.idex_ld  = 1'b1;
         ctl.exmem_ld = 1'b1;
         ctl.memwb_ld = 1'b1;
      end
   end

   assign pc_ld          = ctl.pc_ld;
   assign ifid_ld        = ctl.ifid_ld;
   assign idex_ld        = ctl.idex_ld;
   assign exmem_ld       = ctl.exmem_ld;
   assign memwb_ld       = ctl.memwb_ld;
   assign ifid_flush     = ctl.ifid_flush;
   assign idex_flush     = ctl.idex_flush;
   assign pc_redirect_en = ctl.pc_redirect_en;
   assign pc_redirect    = redirect_q;

   hazard_perf_counters u_perf (
      .clk          (clk),
      .rst_n        (rst_n),
      .istall_inc_i (istall & ~dstall),
      .dstall_inc_i (dstall),
      .flush_inc_i  (flush_inc),
      .istall_cnt_o (istall_cnt),
      .dstall_cnt_o (dstall_cnt),
      .flush_cnt_o  (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl; expected enables and counter values
// are queued as stimulus is applied and compared mid-cycle.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic [7:0]  en;     // {pc,ifid,idex,exmem,memwb ld, ifid_fl, idex_fl, redir_en}
      logic [31:0] redir;
      logic [31:0] icnt;
      logic [31:0] dcnt;
      logic [31:0] fcnt;
   } exp_t;

   localparam logic [7:0] E_FRZ = 8'h00;
   localparam logic [7:0] E_ALL = 8'hF8;
   localparam logic [7:0] E_IST = 8'h3A;
   localparam logic [7:0] E_BR  = 8'hFE;
   localparam logic [7:0] E_BRI = 8'h7E;
   localparam logic [7:0] E_SQW = 8'h7C;
   localparam logic [7:0] E_SQF = 8'hFD;

   // input vector order: {if_req, icache_resp, mem_req, dcache_resp, br_taken}
   localparam logic [4:0] I_IDLE = 5'b00000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic if_req, icache_resp, mem_req, dcache_resp, br_taken;
   logic [31:0] br_target;
   logic pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush;
   logic pc_redirect_en;
   logic [31:0] pc_redirect, istall_cnt, dstall_cnt, flush_cnt;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_req         (if_req),
      .icache_resp    (icache_resp),
      .mem_req        (mem_req),
      .dcache_resp    (dcache_resp),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .pc_ld          (pc_ld),
      .ifid_ld        (ifid_ld),
      .idex_ld        (idex_ld),
      .exmem_ld       (exmem_ld),
      .memwb_ld       (memwb_ld),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .pc_redirect_en (pc_redirect_en),
      .pc_redirect    (pc_redirect),
      .istall_cnt     (istall_cnt),
      .dstall_cnt     (dstall_cnt),
      .flush_cnt      (flush_cnt)
   );

   function automatic exp_t mk(input logic [7:0] en, input logic [31:0] r,
                               input int ic, input int dc, input int fc);
      exp_t e;
      e.en = en; e.redir = r; e.icnt = 32'(ic); e.dcnt = 32'(dc); e.fcnt = 32'(fc);
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t g;
      g.en    = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush,
                 pc_redirect_en};
      g.redir = pc_redirect;
      g.icnt  = istall_cnt;
      g.dcnt  = dstall_cnt;
      g.fcnt  = flush_cnt;
      return g;
   endfunction

   // Drive one cycle of inputs and queue what the DUT should show this cycle
   task automatic apply(input logic [4:0] ins, input exp_t e);
      {if_req, icache_resp, mem_req, dcache_resp, br_taken} = ins;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {if_req, icache_resp, mem_req, dcache_resp, br_taken} = I_IDLE;
      br_target = 32'h0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e, g;
      rst_n = 1'b0;
      br_target = 32'h0;
      apply(I_IDLE, mk(E_FRZ, 32'h0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = sample(); n_cmp++;
      if (g !== e) begin
         n_err++; $display("FAIL reset got=%h exp=%h", g, e);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      exp_t e, g;
      for (int i = 0; i < 3; i++) begin
         apply(I_IDLE, mk(E_ALL, 32'h0, 0, 0, 0));
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL idle[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_dstall();
      logic [4:0] ins [5];
      exp_t ex [5];
      exp_t e, g;
      do_reset();
      ins = '{5'b00100, 5'b00100, 5'b00100, 5'b00110, I_IDLE};
      ex  = '{mk(E_FRZ, 0, 0, 0, 0), mk(E_FRZ, 0, 0, 1, 0), mk(E_FRZ, 0, 0, 2, 0),
              mk(E_ALL, 0, 0, 3, 0), mk(E_ALL, 0, 0, 3, 0)};
      for (int i = 0; i < 5; i++) begin
         apply(ins[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL dstall[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_istall();
      logic [4:0] ins [6];
      exp_t ex [6];
      exp_t e, g;
      do_reset();
      ins = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11000, I_IDLE};
      ex  = '{mk(E_IST, 0, 0, 0, 0), mk(E_IST, 0, 1, 0, 0), mk(E_IST, 0, 2, 0, 0),
              mk(E_IST, 0, 3, 0, 0), mk(E_ALL, 0, 4, 0, 0), mk(E_ALL, 0, 4, 0, 0)};
      for (int i = 0; i < 6; i++) begin
         apply(ins[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL istall[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      logic [4:0] ins [2];
      exp_t ex [2];
      exp_t e, g;
      do_reset();
      br_target = 32'h0000_0040;
      ins = '{5'b00001, I_IDLE};
      ex  = '{mk(E_BR, 0, 0, 0, 0), mk(E_ALL, 0, 0, 0, 1)};
      for (int i = 0; i < 2; i++) begin
         apply(ins[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL branch[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] ins [3];
      exp_t ex [3];
      exp_t e, g;
      do_reset();
      br_target = 32'h0000_0080;
      ins = '{5'b00001, 5'b00001, I_IDLE};
      ex  = '{mk(E_BR, 0, 0, 0, 0), mk(E_BR, 0, 0, 0, 1), mk(E_ALL, 0, 0, 0, 2)};
      for (int i = 0; i < 3; i++) begin
         apply(ins[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL b2b[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_squash();
      logic [4:0] ins [4];
      exp_t ex [4];
      exp_t e, g;
      do_reset();
      br_target = 32'h0000_0060;
      ins = '{5'b10001, 5'b10000, 5'b11000, I_IDLE};
      ex  = '{mk(E_BRI, 32'h00, 0, 0, 0), mk(E_SQW, 32'h60, 1, 0, 1),
              mk(E_SQF, 32'h60, 2, 0, 1), mk(E_ALL, 32'h60, 2, 0, 1)};
      for (int i = 0; i < 4; i++) begin
         apply(ins[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL squash[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_squash_dstall();
      logic [4:0] ins [5];
      exp_t ex [5];
      exp_t e, g;
      do_reset();
      br_target = 32'h0000_0100;
      ins = '{5'b10001, 5'b10100, 5'b11100, 5'b11110, I_IDLE};
      ex  = '{mk(E_BRI, 32'h000, 0, 0, 0), mk(E_FRZ, 32'h100, 1, 0, 1),
              mk(E_FRZ, 32'h100, 1, 1, 1), mk(E_SQF, 32'h100, 1, 2, 1),
              mk(E_ALL, 32'h100, 1, 2, 1)};
      for (int i = 0; i < 5; i++) begin
         apply(ins[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL sq_dstall[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_squash();
      logic [4:0] ins [4];
      exp_t ex [4];
      exp_t e, g;
      do_reset();
      br_target = 32'h0000_0200;
      ins = '{5'b10001, 5'b10000, 5'b10000, I_IDLE};
      ex  = '{mk(E_BRI, 32'h000, 0, 0, 0), mk(E_SQW, 32'h200, 1, 0, 1),
              mk(E_FRZ, 32'h000, 0, 0, 0), mk(E_ALL, 32'h000, 0, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         rst_n = (i == 2) ? 1'b0 : 1'b1;
         apply(ins[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front(); g = sample(); n_cmp++;
         if (g !== e) begin
            n_err++; $display("FAIL rst_squash[%0d] got=%h exp=%h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      {if_req, icache_resp, mem_req, dcache_resp, br_taken} = I_IDLE;
      br_target = 32'h0;
      #2;
      test_reset();
      test_idle();
      test_dstall();
      test_istall();
      test_branch();
      test_back_to_back();
      test_squash();
      test_squash_dstall();
      test_reset_mid_squash();
      if (sb.size() != 0) begin
         n_err++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It resolves instruction-cache misses, data-cache misses and taken-branch redirects into per-register load and flush enables, so that operands forwarded into EX always come from a frozen or coherent pipeline. It includes a squash state that handles branches resolving while an instruction fetch is still outstanding, and it keeps three performance counters.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  IF stage has an instruction-cache read outstanding for the current PC
- icache_resp  in  1  instruction word valid; held high by the cache until PC loads
- mem_req  in  1  EX/MEM instruction is a load or store
- dcache_resp  in  1  data access complete; held high until exmem_ld
- br_taken  in  1  ID/EX instruction is a taken branch or jump (level)
- br_target  in  32  redirect address for br_taken
- pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld  out  1 each  pipeline register load enables
- ifid_flush, idex_flush  out  1 each  load a bubble (NOP, regfile_ld=0) instead of the upstream value
- pc_redirect_en  out  1  PC mux selects pc_redirect over the normal next-PC
- pc_redirect  out  32  saved branch target
- istall_cnt, dstall_cnt, flush_cnt  out  32 each  performance counters

## Operation
- Define dstall = mem_req & !dcache_resp.
- Define istall = (if_req & !icache_resp) | (state==SQUASH & !icache_resp).
- Priority: reset > dstall > state SQUASH > br_taken > istall > normal.
- **Reset** (rst_n low): state=RUN, pc_redirect=0, all counters 0. All *_ld, *_flush and pc_redirect_en are 0.
- **dstall**, any state: every *_ld=0 and all flushes are 0. The whole pipe freezes and br_taken is ignored.
- **RUN, no dstall:**
  - If br_taken & !istall: pc_ld=1 (normal mux takes the branch target). All other *_ld=1, ifid_flush=1, idex_flush=1. flush_cnt increments.
  - If br_taken & istall: pc_ld=0, all other *_ld=1, ifid_flush=1, idex_flush=1. pc_redirect<=br_target, state<=SQUASH. flush_cnt increments.
  - If istall (no branch): pc_ld=0, ifid_ld=0, idex_ld=1 with idex_flush=1 (bubble), exmem_ld=1, memwb_ld=1.
  - Otherwise all *_ld=1 and no flush.
- **SQUASH, no dstall:**
  - Back stages advance: idex_ld, exmem_ld, memwb_ld are 1.
  - ifid_ld=1 with ifid_flush=1 each cycle, so a stale fetch is never decoded.
  - pc_ld=0 until icache_resp.
  - When icache_resp: pc_ld=1, pc_redirect_en=1, state<=RUN. The returned word is discarded by ifid_flush.
- br_taken in SQUASH is ignored. It cannot legally occur, because ID/EX holds only bubbles.
- **Counters** wrap modulo 2^32:
  - dstall_cnt increments each cycle dstall=1.
  - istall_cnt increments each cycle istall=1 and dstall=0.
  - flush_cnt increments as specified above.

## Timing
- All enables are combinational from state and inputs in the same cycle; no added latency.
- Register effects (state, pc_redirect, counters) take place on the rising clk edge.
- A redirect through SQUASH costs (cycles until icache_resp) + 1.
- A dcache miss during SQUASH freezes everything, including the pending redirect. When dstall drops while icache_resp is held, the redirect fires in that same cycle.
- rst_n asserted mid-SQUASH: state returns to RUN and the saved target is discarded.
- Simultaneous br_taken & dstall: no action. The branch stays in ID/EX and is handled on the first non-dstall cycle.

## Structure
- Add to the types package: hazard_state_t enum {RUN, SQUASH}.
- One sub-module, hazard_perf_counters, holds the three 32-bit counters with increment strobes and asynchronous reset.
- The top module contains the state register, the redirect register and the combinational enable logic.

## Test plan
- Reset then idle (if_req=0, mem_req=0): all *_ld=1, no flush, all counters 0.
- mem_req=1 with dcache_resp low for 3 cycles: all *_ld=0 for 3 cycles, then 1. dstall_cnt=3.
- if_req=1 with icache_resp low for 4 cycles: pc_ld=0 and ifid_ld=0, 4 bubbles enter ID/EX. istall_cnt=4.
- br_taken=1 with no stalls: pc_ld=1, ifid_flush=1, idex_flush=1, flush_cnt=1, state stays RUN.
- br_taken=1, br_target=0x60 while icache_resp is low; icache_resp rises 2 cycles later:
  - ifid_flush=1 for 3 cycles.
  - pc_redirect_en=1 and pc_redirect=0x60 on the third cycle, then state=RUN.
- In SQUASH, dstall for 2 cycles overlapping icache_resp: pc_ld=0 during dstall. The redirect fires on the first dstall-free cycle.
- rst_n pulsed low mid-SQUASH: state returns to RUN, pc_redirect=0, counters cleared.
